// File: rtl/sqrt_arb_pkg.sv
// Shared types and constants for the square-root request arbiter.
package sqrt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int SQ_IN_W     = 32;
  localparam int SQ_RES_W    = 64;
  localparam int DEF_TIMEOUT = 1024;

endpackage

// File: rtl/sqrt_req_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or after
// ptr (wrapping) wins. Produces both a one-hot and a binary grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  // Scan requesters starting at ptr and stop at the first one asking.
  always_comb begin : scan
    logic          found;
    logic [IW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/sqrt_req_arbiter.sv
// Shares one square_root_newton unit between N_REQ requesters. Accepts one
// operand at a time, drives the unit's START/DONE/AVAILABLE handshake, and
// returns the result (or a watchdog error) to the requester that was granted.
module sqrt_req_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int IN_W    = SQ_IN_W,
  parameter int RES_W   = SQ_RES_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*IN_W-1:0] req_data,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [RES_W-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  sq_start,
  output logic [IN_W-1:0]       sq_in,
  input  logic [RES_W-1:0]      sq_out,
  input  logic                  sq_done,
  input  logic                  sq_available,
  output logic                  busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT);

  state_t            state_q,  state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     gid_q,    gid_d;
  logic [WW-1:0]     wdog_q,   wdog_d;
  logic [IN_W-1:0]   sq_in_q,  sq_in_d;
  logic [RES_W-1:0]  res_q,    res_d;
  logic              err_q,    err_d;

  logic [N_REQ-1:0]  gnt;
  logic [PW-1:0]     gnt_idx;
  logic              xfer;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // A grant is only offered while idle and the unit reports it can take work.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && sq_available) req_ready = gnt;
  end

  assign xfer = |(req_valid & req_ready);

  // FSM, operand capture, watchdog and result capture.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gid_d    = gid_q;
    wdog_d   = wdog_q;
    sq_in_d  = sq_in_q;
    res_d    = res_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          sq_in_d  = req_data[gnt_idx*IN_W +: IN_W];
          gid_d    = gnt_idx;
          rr_ptr_d = (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
          wdog_d   = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        wdog_d = wdog_q + 1'b1;
        // DONE takes priority over a watchdog expiry in the same cycle.
        if (sq_done) begin
          res_d   = sq_out;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wdog_q == WW'(TIMEOUT-1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[gid_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; a reset aborts any in-flight request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      wdog_q   <= '0;
      sq_in_q  <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      wdog_q   <= wdog_d;
      sq_in_q  <= sq_in_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  // Outputs decoded from state; the response is visible only in RESP.
  always_comb begin
    sq_start  = (state_q == RUN);
    busy      = (state_q != IDLE);
    sq_in     = sq_in_q;
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    if (state_q == RESP) begin
      rsp_valid = N_REQ'(1) << gid_q;
      rsp_data  = res_q;
      rsp_err   = err_q;
    end
  end

endmodule

// File: tb/tb_sqrt_req_arbiter.sv
// Directed bench for sqrt_req_arbiter with a behavioural four-phase sqrt unit.
module tb_sqrt_req_arbiter;

  localparam int N  = 4;
  localparam int IW = 32;
  localparam int RW = 64;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // Main instance, driven by the behavioural sqrt model.
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*IW-1:0] req_data;
  logic [RW-1:0]   rsp_data;
  logic            rsp_err, sq_start, busy;
  logic [IW-1:0]   sq_in;
  logic [RW-1:0]   m_out;
  logic            m_done, m_avail;

  sqrt_req_arbiter #(.N_REQ(N), .IN_W(IW), .RES_W(RW), .TIMEOUT(1024)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .sq_start(sq_start), .sq_in(sq_in), .sq_out(m_out), .sq_done(m_done),
    .sq_available(m_avail), .busy(busy)
  );

  // Watchdog instance, unit inputs driven directly.
  logic [N-1:0]    w_req_valid, w_req_ready, w_rsp_valid, w_rsp_ready;
  logic [N*IW-1:0] w_req_data;
  logic [RW-1:0]   w_rsp_data, w_out;
  logic            w_rsp_err, w_sq_start, w_busy, w_done, w_avail;
  logic [IW-1:0]   w_sq_in;

  sqrt_req_arbiter #(.N_REQ(N), .IN_W(IW), .RES_W(RW), .TIMEOUT(16)) dut_wd (
    .clk(clk), .rstn(rstn),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_data(w_req_data),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_data(w_rsp_data), .rsp_err(w_rsp_err),
    .sq_start(w_sq_start), .sq_in(w_sq_in), .sq_out(w_out), .sq_done(w_done),
    .sq_available(w_avail), .busy(w_busy)
  );

  // Behavioural sqrt: out = isqrt(in << 32), DONE after m_lat cycles.
  int          m_lat;
  int          m_cnt;
  logic        m_busy, m_hold_off;
  logic [31:0] m_op;

  function automatic logic [63:0] isqrt(input logic [31:0] a);
    logic [63:0] x, r, b;
    x = {a, 32'b0};
    r = 64'd0;
    b = 64'h4000_0000_0000_0000;
    while (b > x) b = b >> 2;
    while (b != 64'd0) begin
      if (x >= r + b) begin
        x = x - (r + b);
        r = (r >> 1) + b;
      end else begin
        r = r >> 1;
      end
      b = b >> 2;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_out  <= '0;
      m_op   <= '0;
    end else if (m_busy) begin
      if (!sq_start) m_busy <= 1'b0;
      else if (m_cnt == m_lat - 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_out  <= isqrt(m_op);
      end else m_cnt <= m_cnt + 1;
    end else if (m_done) begin
      if (!sq_start) m_done <= 1'b0;
    end else if (sq_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 0;
      m_op   <= sq_in;
    end
  end

  assign m_avail = !m_busy && !m_done && !sq_start && !m_hold_off;

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int maxc);
    int c;
    c = 0;
    while (rsp_valid == '0 && c < maxc) begin
      nc();
      c++;
    end
    chk("rsp_seen", 64'(rsp_valid != '0), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int c, bad;
    int exp_g[5];
    logic [63:0] exp_r[4];
    int gcnt[4];
    exp_g = '{0, 1, 2, 3, 0};
    exp_r = '{64'h1_0000, 64'h2_0000, 64'h3_0000, 64'h4_0000};
    gcnt  = '{0, 0, 0, 0};

    rstn = 1'b0;
    req_valid = '0; req_data = '0; rsp_ready = '0;
    w_req_valid = '0; w_req_data = '0; w_rsp_ready = '0;
    w_done = 1'b0; w_avail = 1'b1; w_out = 64'hDEAD;
    m_lat = 20; m_hold_off = 1'b0;
    nc(); nc();
    chk("rst_start", 64'(sq_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_sq_in", 64'(sq_in), 64'd0);
    chk("rst_wd_busy", 64'(w_busy), 64'd0);
    rstn = 1'b1;

    // 1. single request, line 0, operand 16
    nc();
    req_data[31:0] = 32'd16;
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 64'(req_ready), 64'h1);
    nc();
    req_valid = '0;
    #1;
    chk("t1_ready_1cyc", 64'(req_ready), 64'h0);
    chk("t1_start_lat1", 64'(sq_start), 64'd1);
    chk("t1_sq_in", 64'(sq_in), 64'd16);
    chk("t1_busy", 64'(busy), 64'd1);
    bad = 0; c = 0;
    while (!m_done && c < 100) begin
      if (sq_start !== 1'b1) bad++;
      nc();
      c++;
    end
    chk("t1_start_held", 64'(bad), 64'd0);
    chk("t1_done_seen", 64'(m_done), 64'd1);
    wait_rsp(5);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t1_rsp_data", rsp_data, 64'h4_0000);
    chk("t1_rsp_err", 64'(rsp_err), 64'd0);
    chk("t1_start_low", 64'(sq_start), 64'd0);
    rsp_ready = 4'b0001;
    nc();
    rsp_ready = '0;
    #1;
    chk("t1_rsp_gone", 64'(rsp_valid), 64'h0);
    chk("t1_idle", 64'(busy), 64'd0);

    // 2. round robin from reset with all lines requesting
    nc(); rstn = 1'b0;
    nc(); rstn = 1'b1;
    m_lat = 3;
    req_data = {32'd16, 32'd9, 32'd4, 32'd1};
    rsp_ready = 4'hF;
    req_valid = 4'hF;
    #1;
    for (int t = 0; t < 5; t++) begin
      c = 0;
      while (req_ready == '0 && c < 50) begin
        nc();
        c++;
      end
      chk($sformatf("t2_grant%0d", t), 64'(req_ready), 64'd1 << exp_g[t]);
      for (int i = 0; i < 4; i++) if (req_ready[i]) gcnt[i]++;
      if (t == 3) begin
        for (int i = 0; i < 4; i++) chk($sformatf("t2_fair%0d", i), 64'(gcnt[i]), 64'd1);
      end
      nc();
      if (t == 4) req_valid = '0;
      wait_rsp(50);
      chk($sformatf("t2_rsp_line%0d", t), 64'(rsp_valid), 64'd1 << exp_g[t]);
      chk($sformatf("t2_rsp_data%0d", t), rsp_data, exp_r[exp_g[t]]);
      nc();
    end
    rsp_ready = '0;

    // 3. response backpressure on line 2
    req_data[95:64] = 32'd25;
    req_valid = 4'b0100;
    #1;
    chk("t3_grant", 64'(req_ready), 64'h4);
    nc();
    req_valid = 4'b1011;
    wait_rsp(50);
    chk("t3_rsp_valid", 64'(rsp_valid), 64'h4);
    chk("t3_rsp_data", rsp_data, 64'h5_0000);
    rsp_ready = 4'b1011;
    bad = 0;
    repeat (50) begin
      nc();
      if (rsp_valid !== 4'b0100 || rsp_data !== 64'h5_0000 || rsp_err !== 1'b0 ||
          req_ready !== 4'b0000 || sq_start !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("t3_hold", 64'(bad), 64'd0);
    rsp_ready = 4'b0100;
    nc();
    rsp_ready = '0;
    #1;
    chk("t3_released", 64'(rsp_valid), 64'h0);
    chk("t3_next_grant", 64'(req_ready), 64'h8);
    req_valid = '0;
    #1;
    chk("t3_no_grant", 64'(req_ready), 64'h0);

    // 5. unit not available
    m_hold_off = 1'b1;
    req_data[31:0] = 32'd1;
    req_valid = 4'b0001;
    bad = 0;
    repeat (10) begin
      nc();
      if (req_ready !== 4'b0000) bad++;
    end
    chk("t5_blocked", 64'(bad), 64'd0);
    chk("t5_idle", 64'(busy), 64'd0);
    m_hold_off = 1'b0;
    #1;
    chk("t5_grant", 64'(req_ready), 64'h1);
    nc();
    req_valid = '0;
    wait_rsp(60);
    chk("t5_rsp_data", rsp_data, 64'h1_0000);
    rsp_ready = 4'b0001;
    nc();
    rsp_ready = '0;

    // 6. asynchronous reset while RUN
    m_lat = 20;
    req_data[63:32] = 32'd4;
    req_valid = 4'b0010;
    #1;
    chk("t6_grant", 64'(req_ready), 64'h2);
    nc();
    req_valid = '0;
    repeat (3) nc();
    chk("t6_running", 64'(sq_start), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_start", 64'(sq_start), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_rsp", 64'(rsp_valid), 64'h0);
    nc();
    rstn = 1'b1;
    req_data[31:0] = 32'd16;
    req_valid = 4'b0001;
    #1;
    chk("t6_grant0", 64'(req_ready), 64'h1);
    nc();
    req_valid = '0;
    wait_rsp(60);
    chk("t6_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t6_rsp_data", rsp_data, 64'h4_0000);
    chk("t6_rsp_err", 64'(rsp_err), 64'd0);
    rsp_ready = 4'b0001;
    nc();
    rsp_ready = '0;

    // 4. watchdog, TIMEOUT = 16, DONE never raised
    w_req_data[127:96] = 32'd7;
    w_req_valid = 4'b1000;
    #1;
    chk("t4_grant", 64'(w_req_ready), 64'h8);
    nc();
    w_req_valid = '0;
    c = 0;
    while (w_sq_start === 1'b1 && c < 40) begin
      c++;
      nc();
    end
    chk("t4_run_cycles", 64'(c), 64'd16);
    chk("t4_rsp_valid", 64'(w_rsp_valid), 64'h8);
    chk("t4_rsp_err", 64'(w_rsp_err), 64'd1);
    chk("t4_rsp_data", w_rsp_data, 64'd0);
    w_rsp_ready = 4'b1000;
    nc();
    w_rsp_ready = '0;

    // DONE in the same cycle as expiry wins; stale DONE in RESP is ignored
    w_req_data[31:0] = 32'd9;
    w_req_valid = 4'b0001;
    #1;
    chk("t4b_grant_wrap", 64'(w_req_ready), 64'h1);
    nc();
    w_req_valid = '0;
    repeat (15) nc();
    chk("t4b_still_run", 64'(w_sq_start), 64'd1);
    w_done = 1'b1;
    w_out = 64'h1234;
    nc();
    chk("t4b_rsp_valid", 64'(w_rsp_valid), 64'h1);
    chk("t4b_rsp_err", 64'(w_rsp_err), 64'd0);
    chk("t4b_rsp_data", w_rsp_data, 64'h1234);
    w_out = 64'h5555;
    nc();
    chk("t4b_stale_data", w_rsp_data, 64'h1234);
    chk("t4b_stale_err", 64'(w_rsp_err), 64'd0);
    w_rsp_ready = 4'b0001;
    nc();
    w_rsp_ready = '0;
    #1;
    chk("t4b_idle", 64'(w_busy), 64'd0);
    nc();
    chk("t4b_stays_idle", 64'(w_busy), 64'd0);
    chk("t4b_no_start", 64'(w_sq_start), 64'd0);
    w_done = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
